// File: rtl/gshare_bp_pkg.sv
// rtl/gshare_bp_pkg.sv - shared types for the gshare branch predictor
package gshare_bp_pkg;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_fsm_t;

endpackage

// File: rtl/gshare_bp_pht.sv
// rtl/gshare_bp_pht.sv - pattern history table, async reads, one sync write port
// The second read port feeds the resolve-side read-modify-write of the counter.
module bp_pht #(
  parameter int HIST_BITS = 10,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clk,
  input  logic [HIST_BITS-1:0] rd_addr_i,
  output logic [CTR_BITS-1:0]  rd_data_o,
  input  logic [HIST_BITS-1:0] upd_addr_i,
  output logic [CTR_BITS-1:0]  upd_data_o,
  input  logic                 we_i,
  input  logic [HIST_BITS-1:0] waddr_i,
  input  logic [CTR_BITS-1:0]  wdata_i
);

  logic [CTR_BITS-1:0] mem_q [2**HIST_BITS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_data_o  = mem_q[rd_addr_i];
  assign upd_data_o = mem_q[upd_addr_i];

endmodule

// File: rtl/gshare_bp.sv
// rtl/gshare_bp.sv - gshare direction predictor with speculative/architected history
// Holds the init-sweep FSM, both history registers, counter update and target adders.
module gshare_bp
  import gshare_bp_pkg::*;
#(
  parameter int HIST_BITS = 10,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid_i,
  input  logic                 pred_is_br_i,
  input  logic [31:0]          pred_pc_i,
  input  logic [31:0]          pred_b_imm_i,
  output logic                 pred_taken_o,
  output logic [31:0]          pred_target_o,
  output logic [HIST_BITS-1:0] pred_idx_o,
  output logic                 ready_o,
  input  logic                 res_valid_i,
  input  logic [HIST_BITS-1:0] res_idx_i,
  input  logic                 res_taken_i,
  input  logic                 res_mispred_i
);

  localparam logic [CTR_BITS-1:0]  CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]  CTR_ONE  = CTR_BITS'(1);
  localparam logic [HIST_BITS-1:0] IDX_LAST = {HIST_BITS{1'b1}};
  localparam logic [HIST_BITS-1:0] IDX_ONE  = HIST_BITS'(1);

  bp_fsm_t              state_q, state_d;
  logic [HIST_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [HIST_BITS-1:0] spec_ghr_q, spec_ghr_d;
  logic [HIST_BITS-1:0] arch_ghr_q, arch_ghr_d;

  logic [CTR_BITS-1:0]  pred_ctr;
  logic [CTR_BITS-1:0]  upd_ctr;
  logic                 pht_we;
  logic [HIST_BITS-1:0] pht_waddr;
  logic [CTR_BITS-1:0]  pht_wdata;
  logic [31:0]          pc_plus4;
  logic [31:0]          pc_plus_imm;

  bp_pht #(
    .HIST_BITS(HIST_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clk       (clk),
    .rd_addr_i (pred_idx_o),
    .rd_data_o (pred_ctr),
    .upd_addr_i(res_idx_i),
    .upd_data_o(upd_ctr),
    .we_i      (pht_we),
    .waddr_i   (pht_waddr),
    .wdata_i   (pht_wdata)
  );

  assign ready_o       = (state_q == BP_RUN);
  assign pred_idx_o    = spec_ghr_q ^ pred_pc_i[HIST_BITS+1:2];
  assign pred_taken_o  = ready_o & pred_is_br_i & pred_ctr[CTR_BITS-1];
  assign pc_plus4      = pred_pc_i + 32'd4;
  assign pc_plus_imm   = pred_pc_i + pred_b_imm_i;
  assign pred_target_o = pred_taken_o ? pc_plus_imm : pc_plus4;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    spec_ghr_d = spec_ghr_q;
    arch_ghr_d = arch_ghr_q;
    pht_we     = 1'b0;
    pht_waddr  = res_idx_i;
    pht_wdata  = upd_ctr;
    case (state_q)
      BP_INIT: begin
        pht_we     = 1'b1;
        pht_waddr  = init_ptr_q;
        pht_wdata  = CTR_INIT;
        init_ptr_d = init_ptr_q + IDX_ONE;
        if (init_ptr_q == IDX_LAST) begin
          state_d = BP_RUN;
        end
      end
      BP_RUN: begin
        if (pred_valid_i && pred_is_br_i) begin
          spec_ghr_d = {spec_ghr_q[HIST_BITS-2:0], pred_taken_o};
        end
        if (res_valid_i) begin
          arch_ghr_d = {arch_ghr_q[HIST_BITS-2:0], res_taken_i};
          pht_we     = 1'b1;
          if (res_taken_i) begin
            pht_wdata = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + CTR_ONE;
          end else begin
            pht_wdata = (upd_ctr == '0) ? upd_ctr : upd_ctr - CTR_ONE;
          end
          // Restore overrides any same-cycle speculative shift.
          if (res_mispred_i) begin
            spec_ghr_d = {arch_ghr_q[HIST_BITS-2:0], res_taken_i};
          end
        end
      end
      default: state_d = BP_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BP_INIT;
      init_ptr_q <= '0;
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      spec_ghr_q <= spec_ghr_d;
      arch_ghr_q <= arch_ghr_d;
    end
  end

endmodule

// File: tb/tb_gshare_bp.sv
// tb/tb_gshare_bp.sv - directed scoreboard bench for gshare_bp (HIST_BITS=4, CTR_BITS=2)
module tb_gshare_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid_i, pred_is_br_i;
  logic [31:0] pred_pc_i, pred_b_imm_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic [3:0]  pred_idx_o;
  logic        ready_o;
  logic        res_valid_i, res_taken_i, res_mispred_i;
  logic [3:0]  res_idx_i;

  typedef struct {
    string       name;
    logic        rdy;
    logic        tk;
    logic [31:0] tgt;
    logic [3:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  gshare_bp #(.HIST_BITS(4), .CTR_BITS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .pred_valid_i (pred_valid_i),
    .pred_is_br_i (pred_is_br_i),
    .pred_pc_i    (pred_pc_i),
    .pred_b_imm_i (pred_b_imm_i),
    .pred_taken_o (pred_taken_o),
    .pred_target_o(pred_target_o),
    .pred_idx_o   (pred_idx_o),
    .ready_o      (ready_o),
    .res_valid_i  (res_valid_i),
    .res_idx_i    (res_idx_i),
    .res_taken_i  (res_taken_i),
    .res_mispred_i(res_mispred_i)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: every presented prediction is checked against the next queued expectation.
  always @(negedge clk) begin
    if (pred_valid_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: prediction seen with empty queue, idx %h", pred_idx_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, "ready", {31'd0, ready_o}, {31'd0, e.rdy});
        chk(e.name, "taken", {31'd0, pred_taken_o}, {31'd0, e.tk});
        chk(e.name, "target", pred_target_o, e.tgt);
        chk(e.name, "idx", {28'd0, pred_idx_o}, {28'd0, e.idx});
      end
    end
  end

  task automatic pred(input string nm, input logic [31:0] pc, input logic br,
                      input logic rdy, input logic tk, input logic [31:0] tgt, input logic [3:0] idx);
    exp_t e;
    pred_valid_i = 1'b1;
    pred_is_br_i = br;
    pred_pc_i    = pc;
    pred_b_imm_i = 32'h20;
    e.name = nm; e.rdy = rdy; e.tk = tk; e.tgt = tgt; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic res(input logic [3:0] idx, input logic tk, input logic mis);
    res_valid_i   = 1'b1;
    res_idx_i     = idx;
    res_taken_i   = tk;
    res_mispred_i = mis;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pred_valid_i = 1'b0;
    pred_is_br_i = 1'b0;
    res_valid_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pred_valid_i = 0; pred_is_br_i = 0; pred_pc_i = 0; pred_b_imm_i = 0;
    res_valid_i = 0; res_idx_i = 0; res_taken_i = 0; res_mispred_i = 0;
    tick();
    pred("reset", 32'h100, 1, 0, 0, 32'h104, 4'h0); tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pred("init_sweep", 32'h100, 1, 0, 0, 32'h104, 4'h0); tick();
    end

    pred("first_run", 32'h100, 1, 1, 1, 32'h120, 4'h0); tick();
    pred("ghr_shift", 32'h100, 1, 1, 1, 32'h120, 4'h1); tick();

    res(4'd5, 0, 0); tick();
    res(4'd5, 0, 0); tick();
    pred("ctr_zero", 32'h118, 1, 1, 0, 32'h11C, 4'h5); tick();
    res(4'd5, 0, 0); tick();
    pred("sat_low", 32'h10C, 1, 1, 0, 32'h110, 4'h5); tick();
    for (int i = 0; i < 4; i++) begin
      res(4'd5, 1, 0); tick();
    end
    pred("ctr_three", 32'h124, 1, 1, 1, 32'h144, 4'h5); tick();
    res(4'd5, 0, 0); tick();
    pred("sat_high", 32'h130, 1, 1, 1, 32'h150, 4'h5); tick();
    res(4'd5, 0, 0); tick();
    pred("ctr_one", 32'h118, 1, 1, 0, 32'h11C, 4'h5); tick();

    res(4'd14, 0, 0); tick();
    res(4'd14, 0, 0); tick();
    res(4'd14, 0, 1); tick();
    pred("spec_a", 32'h100, 1, 1, 1, 32'h120, 4'h0); tick();
    pred("spec_b", 32'h100, 1, 1, 1, 32'h120, 4'h1); tick();
    pred("spec_c", 32'h100, 1, 1, 1, 32'h120, 4'h3); tick();
    pred("mis_same_cyc", 32'h100, 1, 1, 1, 32'h120, 4'h7);
    res(4'd2, 0, 1); tick();
    pred("after_restore", 32'h100, 1, 1, 1, 32'h120, 4'h0); tick();
    res(4'd2, 1, 1); tick();
    pred("arch_hist", 32'h100, 1, 1, 1, 32'h120, 4'h1); tick();

    pred("rw_old", 32'h100, 1, 1, 1, 32'h120, 4'h3);
    res(4'd3, 0, 0); tick();
    pred("rw_new", 32'h110, 1, 1, 0, 32'h114, 4'h3); tick();
    pred("not_branch", 32'h110, 0, 1, 0, 32'h114, 4'hA); tick();

    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pred("sweep_part", 32'h100, 1, 0, 0, 32'h104, 4'h0);
      res(4'd5, 1, 1); tick();
    end
    rst = 1'b1;
    res(4'd5, 1, 1); tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pred("sweep_restart", 32'h100, 1, 0, 0, 32'h104, 4'h0);
      res(4'd9, 1, 1); tick();
    end
    pred("entry_15", 32'h13C, 1, 1, 1, 32'h15C, 4'hF);
    res(4'd15, 0, 1); tick();
    for (int k = 0; k < 15; k++) begin
      pred("entry_init", 32'h100 + 32'(4 * k), 1, 1, 1, 32'h120 + 32'(4 * k), 4'(k));
      res(4'd15, 0, 1); tick();
    end

    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never matched, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
